// File: rtl/controle_fluxo_agua_sequencial.sv
// Water-flow controller: synchronised and debounced sensors feed a request that drives a
// four-state valve/pump sequencer with a run-time fault and a fault acknowledge.
module controle_fluxo_agua_sequencial #(
  parameter int unsigned N         = 4,
  parameter int unsigned DEB       = 3,
  parameter int unsigned START_DLY = 2,
  parameter int unsigned MAX_RUN   = 16,
  parameter int unsigned MIN_AUX   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             sensors,
  input  logic                     fault_clr,
  output logic                     valve_open,
  output logic                     pump_on,
  output logic                     fault,
  output logic [1:0]               state,
  output logic [$clog2(N+1)-1:0]   active_cnt
);

  localparam int unsigned CW  = $clog2(N + 1);
  // Debounce counter only needs to hold 0..DEB-1; the DEB-th differing sample updates the bit.
  localparam int unsigned DBW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int unsigned LIM = (START_DLY > MAX_RUN) ? START_DLY : MAX_RUN;
  localparam int unsigned DW  = $clog2(LIM + 1);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StStart = 2'b01;
  localparam logic [1:0] StRun   = 2'b10;
  localparam logic [1:0] StFault = 2'b11;

  logic [N-1:0]   sync1_q, sync2_q;
  logic [N-1:0]   deb_q, deb_d;
  logic [DBW-1:0] deb_cnt_q [N];
  logic [DBW-1:0] deb_cnt_d [N];
  logic [CW-1:0]  aux_cnt, total_cnt;
  logic           req;
  logic [1:0]     state_q, state_d;
  logic [DW-1:0]  dwell_q, dwell_d;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < N; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DBW'(DEB - 1)) begin
        deb_d[i]     = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    aux_cnt   = '0;
    total_cnt = '0;
    for (int i = 0; i < N; i++) begin
      total_cnt = total_cnt + CW'(deb_q[i]);
      if (i < N - 2) begin
        aux_cnt = aux_cnt + CW'(deb_q[i]);
      end
    end
  end

  assign req = deb_q[N-1] & deb_q[N-2] & (aux_cnt >= CW'(MIN_AUX));

  // Request loss is checked first so it beats a dwell limit reached on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req) state_d = StStart;
      end
      StStart: begin
        if (!req) begin
          state_d = StIdle;
        end else if (dwell_q >= DW'(START_DLY - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!req) begin
          state_d = StIdle;
        end else if (dwell_q >= DW'(MAX_RUN - 1)) begin
          state_d = StFault;
        end
      end
      default: begin
        if (fault_clr && !req) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      dwell_d = '0;
    end else if (dwell_q == {DW{1'b1}}) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < N; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sensors;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < N; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dwell_q    <= '0;
      valve_open <= 1'b0;
      pump_on    <= 1'b0;
      fault      <= 1'b0;
      active_cnt <= '0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      valve_open <= (state_d == StStart) || (state_d == StRun);
      pump_on    <= (state_d == StRun);
      fault      <= (state_d == StFault);
      active_cnt <= total_cnt;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_controle_fluxo_agua_sequencial.sv
// Self-checking bench: directed scenarios plus random sensor traffic compared against a
// cycle-level behavioural model of the controller.
module tb_controle_fluxo_agua_sequencial;

  localparam int unsigned N         = 4;
  localparam int unsigned DEB       = 3;
  localparam int unsigned START_DLY = 2;
  localparam int unsigned MAX_RUN   = 16;
  localparam int unsigned MIN_AUX   = 1;
  localparam int unsigned CW        = 3;

  localparam logic [1:0] M_IDLE  = 2'b00;
  localparam logic [1:0] M_START = 2'b01;
  localparam logic [1:0] M_RUN   = 2'b10;
  localparam logic [1:0] M_FAULT = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  sensors = '0;
  logic          fault_clr = 1'b0;
  logic          valve_open, pump_on, fault;
  logic [1:0]    state;
  logic [CW-1:0] active_cnt;

  int checks = 0;
  int passed = 0;

  controle_fluxo_agua_sequencial #(
    .N(N), .DEB(DEB), .START_DLY(START_DLY), .MAX_RUN(MAX_RUN), .MIN_AUX(MIN_AUX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sensors(sensors), .fault_clr(fault_clr),
    .valve_open(valve_open), .pump_on(pump_on), .fault(fault),
    .state(state), .active_cnt(active_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw levels delayed two samples, a bit accepts a new level once the
  // last DEB samples all disagree with it, and the FSM counts cycles spent in each state.
  logic [N-1:0]  m_s1, m_s2, m_deb;
  logic [N-1:0]  m_hist [DEB];
  logic [1:0]    m_state;
  int            m_tis;
  logic [CW-1:0] m_cnt;

  logic [7:0] dut_out, exp_out;
  assign dut_out = {state, valve_open, pump_on, fault, active_cnt};
  always_comb begin
    exp_out = {m_state, (m_state == M_START) || (m_state == M_RUN), m_state == M_RUN,
               m_state == M_FAULT, m_cnt};
  end

  function automatic int popc(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_state = M_IDLE; m_tis = 0; m_cnt = '0;
    for (int i = 0; i < DEB; i++) m_hist[i] = '0;
  endtask

  task automatic model_step(input logic [N-1:0] raw, input logic clr);
    logic       req;
    logic [1:0] nxt;
    logic [N-1:0] aux;
    aux = m_deb & N'((1 << (N - 2)) - 1);
    req = m_deb[N-1] && m_deb[N-2] && (popc(aux) >= int'(MIN_AUX));
    nxt = m_state;
    case (m_state)
      M_IDLE:  if (req) nxt = M_START;
      M_START: if (!req) nxt = M_IDLE; else if (m_tis + 1 >= int'(START_DLY)) nxt = M_RUN;
      M_RUN:   if (!req) nxt = M_IDLE; else if (m_tis + 1 >= int'(MAX_RUN)) nxt = M_FAULT;
      default: if (clr && !req) nxt = M_IDLE;
    endcase
    m_cnt = CW'(popc(m_deb));
    m_tis = (nxt != m_state) ? 0 : m_tis + 1;
    m_state = nxt;
    for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_s2;
    for (int b = 0; b < N; b++) begin
      bit all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (m_hist[i][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) m_deb[b] = ~m_deb[b];
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic tick();
    logic [N-1:0] raw;
    logic clr;
    raw = sensors;
    clr = fault_clr;
    @(posedge clk);
    model_step(raw, clr);
    #1;
  endtask

  // Pulses reset between edges; outputs must clear before any edge arrives.
  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_out !== 8'h00) $display("FAIL reset_async got=%h want=00", dut_out);
    else passed++;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (dut_out !== 8'h00) $display("FAIL reset_held got=%h want=00", dut_out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_start_sequence();
    sensors = 4'b1101;
    test_reset();
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (dut_out !== exp_out) $display("FAIL start_seq e=%0d got=%h want=%h", e, dut_out, exp_out);
      else passed++;
      if (e == 5 || e == 6 || e == 8) begin
        checks++;
        if (e == 5 && state !== 2'b00) $display("FAIL start_e5 got=%b want=00", state);
        else if (e == 6 && state !== 2'b01) $display("FAIL start_e6 got=%b want=01", state);
        else if (e == 8 && {state, pump_on} !== 3'b101)
          $display("FAIL start_e8 got=%b/%b want=10/1", state, pump_on);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_in_run();
    checks++;
    if (state !== 2'b10) $display("FAIL reset_in_run_pre got=%b want=10", state);
    else passed++;
    test_reset();
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if (dut_out !== exp_out) $display("FAIL restart e=%0d got=%h want=%h", e, dut_out, exp_out);
      else passed++;
    end
  endtask

  task automatic test_debounce();
    sensors = 4'b1100;
    test_reset();
    for (int e = 0; e < 24; e++) begin
      if (e == 10) sensors = 4'b1110;
      if (e == 12) sensors = 4'b1100;
      tick();
      checks++;
      if (dut_out !== exp_out || state !== 2'b00)
        $display("FAIL debounce e=%0d got=%h want=%h", e, dut_out, exp_out);
      else passed++;
    end
  endtask

  task automatic test_sweep();
    for (int p = 0; p < 16; p++) begin
      logic [3:0] v;
      logic want_req;
      v = 4'(p);
      want_req = v[3] & v[2] & (v[1] | v[0]);
      sensors = v;
      test_reset();
      for (int e = 0; e < 10; e++) begin
        tick();
        checks++;
        if (dut_out !== exp_out) $display("FAIL sweep p=%0d got=%h want=%h", p, dut_out, exp_out);
        else passed++;
      end
      checks++;
      if (state !== (want_req ? 2'b10 : 2'b00))
        $display("FAIL sweep_req p=%0d got=%b want_req=%b", p, state, want_req);
      else passed++;
    end
  endtask

  task automatic test_timeout_fault();
    sensors = 4'b1111;
    test_reset();
    for (int e = 1; e <= 24; e++) begin
      tick();
      checks++;
      if (dut_out !== exp_out) $display("FAIL timeout e=%0d got=%h want=%h", e, dut_out, exp_out);
      else passed++;
    end
    checks++;
    if ({state, fault, valve_open} !== 4'b1110)
      $display("FAIL fault_enter got=%b/%b/%b want=11/1/0", state, fault, valve_open);
    else passed++;
    fault_clr = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    checks++;
    if (state !== 2'b11) $display("FAIL fault_clr_req got=%b want=11", state);
    else passed++;
    fault_clr = 1'b0;
    sensors = 4'b0000;
    for (int e = 0; e < 7; e++) tick();
    checks++;
    if (state !== 2'b11) $display("FAIL fault_hold got=%b want=11", state);
    else passed++;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (dut_out !== exp_out || state !== 2'b00)
      $display("FAIL fault_clear got=%h want=%h", dut_out, exp_out);
    else passed++;
  endtask

  // Enters RUN, waits `extra` cycles, then drops an aux sensor; IDLE follows on the 6th edge.
  task automatic run_then_drop(input int extra, input string name);
    int budget = 0;
    sensors = 4'b1101;
    test_reset();
    while (m_state != M_RUN && budget < 40) begin
      tick();
      budget++;
    end
    checks++;
    if (state !== 2'b10) $display("FAIL %s_run got=%b want=10", name, state);
    else passed++;
    for (int e = 0; e < extra; e++) tick();
    sensors = 4'b1001;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (dut_out !== exp_out) $display("FAIL %s e=%0d got=%h want=%h", name, e, dut_out, exp_out);
      else passed++;
    end
    checks++;
    if (state !== 2'b00) $display("FAIL %s_idle got=%b want=00", name, state);
    else passed++;
  endtask

  task automatic test_drop();
    run_then_drop(2, "drop_mid");
    run_then_drop(int'(MAX_RUN) - 6, "drop_limit");
  endtask

  task automatic test_random();
    sensors = '0;
    test_reset();
    for (int k = 0; k < 60; k++) begin
      int hold;
      sensors = N'($urandom);
      hold = (($urandom & 3) == 0) ? int'($urandom_range(15, 30)) : int'($urandom_range(1, 8));
      for (int e = 0; e < hold; e++) begin
        fault_clr = (($urandom & 3) == 0);
        tick();
        checks++;
        if (dut_out !== exp_out)
          $display("FAIL random k=%0d e=%0d got=%h want=%h", k, e, dut_out, exp_out);
        else passed++;
      end
    end
    fault_clr = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_sequence();
    test_reset_in_run();
    test_debounce();
    test_sweep();
    test_timeout_fault();
    test_drop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
